// File: rtl/reduce_result_packer_pkg.sv
// Shared constants and types for the reduction result packer.
package reduce_result_packer_pkg;

    localparam int N_LANES    = 8;
    localparam int LANE_BITS  = 64;
    localparam int LANE_BYTES = LANE_BITS / 8;

    typedef logic [LANE_BITS-1:0]            lane_t;
    typedef logic [N_LANES*LANE_BITS-1:0]    beat_t;
    typedef logic [N_LANES*LANE_BYTES-1:0]   keep_t;

endpackage

// File: rtl/reduce_pack_oreg.sv
// Single-entry valid/ready holding register for a packed beat (data, keep, last).
module reduce_pack_oreg #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    output logic              load_ready,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast
);
    import reduce_result_packer_pkg::*;

    // The entry can take a new beat when empty or when its beat leaves this cycle.
    assign load_ready = ~m_tvalid | m_tready;

    // Hold the beat until the downstream handshake; a same-cycle load replaces it with no bubble.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            m_tvalid <= 1'b1;
            m_tdata  <= load_data;
            m_tkeep  <= load_keep;
            m_tlast  <= load_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/reduce_result_packer.sv
// Packs a stream of reduction results into N_LANES-wide output beats.
module reduce_result_packer #(
    parameter int N_LANES   = reduce_result_packer_pkg::N_LANES,
    parameter int LANE_BITS = reduce_result_packer_pkg::LANE_BITS
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANE_BITS-1:0]         in_data,
    input  logic                         in_last,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [N_LANES*LANE_BITS-1:0] m_tdata,
    output logic [N_LANES*LANE_BITS/8-1:0] m_tkeep,
    output logic                         m_tlast,
    output logic [31:0]                  cnt_in,
    output logic [31:0]                  cnt_out
);
    import reduce_result_packer_pkg::*;

    localparam int LANE_B = LANE_BITS / 8;
    localparam int KEEP_W = N_LANES * LANE_B;
    localparam int DATA_W = N_LANES * LANE_BITS;
    localparam int IDX_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    logic [IDX_W-1:0]     lidx;
    logic [LANE_BITS-1:0] pbuf [N_LANES];
    logic                 accept;
    logic                 closing;
    logic [DATA_W-1:0]    beat;
    logic [KEEP_W-1:0]    beat_keep;

    assign accept  = in_valid & in_ready;
    assign closing = accept & (in_last | (lidx == LAST_IDX));

    // Assemble the completed beat: stored lanes below lidx, the incoming result at lidx, zeros above.
    always_comb begin
        // NOTE: defaults first so no path leaves beat/beat_keep unassigned (no latch).
        beat      = '0;
        beat_keep = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (IDX_W'(i) == lidx) begin
                beat[i*LANE_BITS +: LANE_BITS] = in_data;
            end else begin
                beat[i*LANE_BITS +: LANE_BITS] = pbuf[i];
            end
            if (IDX_W'(i) <= lidx) begin
                beat_keep[i*LANE_B +: LANE_B] = '1;
            end
        end
    end

    // Store accepted results lane by lane; a closing result empties the buffer for the next beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lidx <= '0;
            // NOTE: pbuf is reset (not left uninitialised) because lanes above lidx must read as zero in a short beat.
            for (int i = 0; i < N_LANES; i++) pbuf[i] <= '0;
        end else if (accept) begin
            if (closing) begin
                lidx <= '0;
                for (int i = 0; i < N_LANES; i++) pbuf[i] <= '0;
            end else begin
                pbuf[lidx] <= in_data;
                lidx       <= lidx + 1'b1;
            end
        end
    end

    // Count input and output handshakes; both wrap naturally at 32 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_in  <= '0;
            cnt_out <= '0;
        end else begin
            if (accept)              cnt_in  <= cnt_in + 32'd1;
            if (m_tvalid && m_tready) cnt_out <= cnt_out + 32'd1;
        end
    end

    reduce_pack_oreg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_oreg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (closing),
        .load_data  (beat),
        .load_keep  (beat_keep),
        .load_last  (in_last),
        .load_ready (in_ready),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast)
    );

endmodule

// File: tb/tb_reduce_result_packer.sv
// Directed self-checking bench for reduce_result_packer.
module tb_reduce_result_packer;
    import reduce_result_packer_pkg::*;

    localparam int CW = N_LANES * LANE_BITS;

    logic        aclk;
    logic        aresetn;
    logic        in_valid;
    logic        in_ready;
    lane_t       in_data;
    logic        in_last;
    logic        m_tvalid;
    logic        m_tready;
    beat_t       m_tdata;
    keep_t       m_tkeep;
    logic        m_tlast;
    logic [31:0] cnt_in;
    logic [31:0] cnt_out;

    int checks = 0;
    int errors = 0;

    reduce_result_packer #(
        .N_LANES   (N_LANES),
        .LANE_BITS (LANE_BITS)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .cnt_in   (cnt_in),
        .cnt_out  (cnt_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic drive(input logic v, input lane_t d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    // Expected beat with n lanes holding base, base+1, ...; remaining lanes zero.
    function automatic beat_t mk_beat(input lane_t base, input int n);
        beat_t b = '0;
        for (int i = 0; i < n; i++) b[i*LANE_BITS +: LANE_BITS] = base + lane_t'(i);
        return b;
    endfunction

    function automatic keep_t mk_keep(input int n);
        keep_t k = '0;
        for (int i = 0; i < n * LANE_BYTES; i++) k[i] = 1'b1;
        return k;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn  = 1'b0;
        m_tready = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(negedge aclk);

        // Reset state
        check("rst_tvalid", CW'(m_tvalid), CW'(0));
        check("rst_tdata", m_tdata, '0);
        check("rst_cnt_in", CW'(cnt_in), CW'(0));
        check("rst_cnt_out", CW'(cnt_out), CW'(0));
        aresetn = 1'b1;
        check("rel_in_ready", CW'(in_ready), CW'(1));

        // Full beat 1..8 with last on the 8th
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, lane_t'(k + 1), k == 7);
            step();
            if (k == 6) check("t1_not_yet", CW'(m_tvalid), CW'(0));
        end
        drive(1'b0, '0, 1'b0);
        check("t1_tvalid", CW'(m_tvalid), CW'(1));
        check("t1_tdata", m_tdata, mk_beat(64'h1, 8));
        check("t1_tkeep", CW'(m_tkeep), CW'(mk_keep(8)));
        check("t1_tlast", CW'(m_tlast), CW'(1));
        check("t1_cnt_in", CW'(cnt_in), CW'(8));
        step();
        check("t1_cnt_out", CW'(cnt_out), CW'(1));
        check("t1_drained", CW'(m_tvalid), CW'(0));

        // Partial beat A,B,C with last on the 3rd
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, lane_t'(64'hA + 64'(k)), k == 2);
            step();
        end
        drive(1'b0, '0, 1'b0);
        check("t2_tvalid", CW'(m_tvalid), CW'(1));
        check("t2_tdata", m_tdata, mk_beat(64'hA, 3));
        check("t2_tkeep", CW'(m_tkeep), CW'(64'h0000_0000_00FF_FFFF));
        check("t2_tlast", CW'(m_tlast), CW'(1));
        step();

        // Backpressure: a full beat stalls for 10 cycles while more results are offered
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, lane_t'(64'h100 + 64'(k)), 1'b0);
            step();
        end
        check("t3_b1_tvalid", CW'(m_tvalid), CW'(1));
        check("t3_b1_tlast", CW'(m_tlast), CW'(0));
        drive(1'b1, lane_t'(64'h200), 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("t3_stall_in_ready", CW'(in_ready), CW'(0));
            check("t3_stall_tdata", m_tdata, mk_beat(64'h100, 8));
        end
        check("t3_stall_cnt_in", CW'(cnt_in), CW'(19));
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, lane_t'(64'h200 + 64'(k)), k == 7);
            step();
            if (k == 0) begin
                check("t3_b1_gone", CW'(m_tvalid), CW'(0));
                check("t3_cnt_out_mid", CW'(cnt_out), CW'(3));
            end
        end
        drive(1'b0, '0, 1'b0);
        check("t3_b2_tvalid", CW'(m_tvalid), CW'(1));
        check("t3_b2_tdata", m_tdata, mk_beat(64'h200, 8));
        check("t3_b2_tlast", CW'(m_tlast), CW'(1));
        step();
        check("t3_no_dup", CW'(m_tvalid), CW'(0));
        check("t3_cnt_in", CW'(cnt_in), CW'(27));
        check("t3_cnt_out", CW'(cnt_out), CW'(4));

        // Back-to-back: 16 results without last, then one with last
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, lane_t'(64'h300 + 64'(k)), k == 16);
            step();
            check("t4_tvalid", CW'(m_tvalid), CW'(k == 7 || k == 15 || k == 16));
            if (k == 7) begin
                check("t4_b1_tdata", m_tdata, mk_beat(64'h300, 8));
                check("t4_b1_tlast", CW'(m_tlast), CW'(0));
            end
            if (k == 15) begin
                check("t4_b2_tdata", m_tdata, mk_beat(64'h308, 8));
                check("t4_b2_tlast", CW'(m_tlast), CW'(0));
            end
            if (k == 16) begin
                check("t4_b3_tdata", m_tdata, mk_beat(64'h310, 1));
                check("t4_b3_tkeep", CW'(m_tkeep), CW'(64'h0000_0000_0000_00FF));
                check("t4_b3_tlast", CW'(m_tlast), CW'(1));
            end
        end
        drive(1'b0, '0, 1'b0);
        step();
        check("t4_cnt_in", CW'(cnt_in), CW'(44));
        check("t4_cnt_out", CW'(cnt_out), CW'(7));

        // Reset after 5 of 8 results; the partial beat must be discarded
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, lane_t'(64'h400 + 64'(k)), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        aresetn = 1'b0;
        #1;
        check("t5_rst_tvalid", CW'(m_tvalid), CW'(0));
        check("t5_rst_cnt_in", CW'(cnt_in), CW'(0));
        check("t5_rst_cnt_out", CW'(cnt_out), CW'(0));
        check("t5_rst_tdata", m_tdata, '0);
        step();
        aresetn = 1'b1;
        check("t5_rel_in_ready", CW'(in_ready), CW'(1));
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, lane_t'(64'h500 + 64'(k)), k == 7);
            step();
        end
        drive(1'b0, '0, 1'b0);
        check("t5_tvalid", CW'(m_tvalid), CW'(1));
        check("t5_tdata", m_tdata, mk_beat(64'h500, 8));
        step();
        check("t5_cnt_in", CW'(cnt_in), CW'(8));
        check("t5_cnt_out", CW'(cnt_out), CW'(1));

        // Counter wrap on cnt_in
        force dut.cnt_in = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_in;
        #1;
        check("t6_preload", CW'(cnt_in), CW'(32'hFFFF_FFFF));
        drive(1'b1, lane_t'(64'h600), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("t6_cnt_in_wrap", CW'(cnt_in), CW'(0));
        check("t6_tdata", m_tdata, mk_beat(64'h600, 1));
        step();
        check("t6_cnt_out", CW'(cnt_out), CW'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduce_result_packer.md
REDUCE_RESULT_PACKER -- requirements
Module: reduce_result_packer

Interface
REQ-001 Parameter N_LANES, default 8: number of 64-bit result lanes per output beat.
REQ-002 Parameter LANE_BITS, default 64: width of one reduction result.
REQ-003 aclk  in  1  single clock; all state updates on the rising edge.
REQ-004 aresetn  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  reduction result valid.
REQ-006 in_ready  out  1  result accepted when in_valid & in_ready.
REQ-007 in_data  in  LANE_BITS  reduction result (e.g. per-packet max).
REQ-008 in_last  in  1  final result of the current output packet.
REQ-009 m_tvalid  out  1  packed beat valid.
REQ-010 m_tready  in  1  downstream ready.
REQ-011 m_tdata  out  N_LANES*LANE_BITS  packed results; lane i occupies bits [i*LANE_BITS +: LANE_BITS].
REQ-012 m_tkeep  out  N_LANES*LANE_BITS/8  byte enables of the filled lanes.
REQ-013 m_tlast  out  1  beat closes the output packet.
REQ-014 cnt_in  out  32  count of accepted results.
REQ-015 cnt_out  out  32  count of emitted beats.

Function
REQ-016 Two storage stages:
- pack buffer: pbuf, lane index lidx, range 0..N_LANES-1;
- output register: obuf, keep, last, m_tvalid.
REQ-017 in_ready SHALL equal ~m_tvalid | m_tready; this is the only combinational path from m_tready to in_ready.
REQ-018 On acceptance, in_data is written to pbuf lane lidx.
- Not closing (lidx < N_LANES-1 and in_last = 0): lidx increments.
- Closing (lidx = N_LANES-1 or in_last = 1): go to REQ-019.
REQ-019 On a closing acceptance in cycle t, next cycle (t+1):
- m_tvalid = 1 with the completed beat, latency 1 cycle;
- lanes 0..lidx carry the accepted results, lanes above lidx are zero;
- m_tkeep has bytes 0..(lidx+1)*LANE_BITS/8-1 set;
- m_tlast = in_last;
- lidx returns to 0 and pbuf is cleared.
REQ-020 m_tvalid clears after a handshake (m_tvalid & m_tready) unless a new closing acceptance occurs in the same cycle, in which case the new beat is loaded with no bubble.
REQ-021 While m_tvalid = 1 and m_tready = 0: m_tdata, m_tkeep and m_tlast are held stable and no result is accepted.
REQ-022 Sustained throughput is one result per cycle when m_tready = 1.
REQ-023 in_last at lidx = N_LANES-1 yields a single full beat with m_tlast = 1; no empty beat follows.
REQ-024 in_last at lidx = 0 yields a one-lane beat: m_tkeep = 0x0000_0000_0000_00FF for the defaults.
REQ-025 Counters:
- cnt_in increments on each input handshake; cnt_out increments on each output handshake;
- both are 32-bit and wrap from 0xFFFF_FFFF to 0.

Reset
REQ-026 Assertion of aresetn = 0 SHALL immediately clear:
- lidx, pbuf, obuf, m_tvalid, m_tkeep, m_tlast, cnt_in, cnt_out;
- m_tdata reads 0 during reset.
REQ-027 A partially packed beat or a stalled output beat present at reset is discarded; none is emitted after release.
REQ-028 in_ready is 1 in the first cycle after reset release.

Structure
REQ-029 Shared package contents:
- constants N_LANES and LANE_BITS;
- typedef lane_t (LANE_BITS wide);
- typedef beat_t (N_LANES*LANE_BITS wide).
REQ-030 The output register stage SHALL be one sub-module, reduce_pack_oreg: a single-entry valid/ready holding register carrying data, keep and last.
REQ-031 The lane indexing and pack buffer remain in the top module.

Verification
REQ-032 Continuous input: 8 results 0x1..0x8, last on the 8th, m_tready = 1.
- Expected: one beat at cycle +1, lane i = i+1, m_tkeep all ones, m_tlast = 1, cnt_in = 8, cnt_out = 1.
REQ-033 Partial beat: 3 results 0xA,0xB,0xC, last on the 3rd.
- Expected: m_tkeep = 0x0000_0000_00FF_FFFF, lanes 3..7 = 0, m_tlast = 1.
REQ-034 Backpressure: m_tready = 0 for 10 cycles with a beat pending and 16 results offered.
- Expected: in_ready = 0 and m_tdata stable throughout.
- After release: two beats, in order, no loss, no duplicates.
REQ-035 Back-to-back: 16 results, no last, then 1 result with last, m_tready = 1.
- Expected: beats at full rate with m_tlast = 0,0,1; third beat has one lane.
REQ-036 Reset mid-operation: reset asserted after 5 of 8 results.
- Expected: m_tvalid = 0 and counters = 0.
- Expected: the next 8 results produce a beat containing only the new data.
REQ-037 Counter wrap: cnt_in preloaded to 0xFFFF_FFFF, then one accepted result.
- Expected: cnt_in = 0.
